// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one synchronous data memory port
// between the CPU load/store path and the debug readout path.
//
// Ports:
//   clk_in, rst        clock, async active-low reset
//   cpu_req/we/addr/wdata  CPU access request (held until ack)
//   cpu_stall          combinational CPU freeze
//   cpu_ack/cpu_rdata  access done pulse and load data
//   hold/hold_ack      debug freeze request and grant
//   dbg_addr           debug read address
//   dbg_rdata/valid    registered debug read data
//   mem_en/we/addr/wdata  registered memory controls
//   mem_rdata          memory read data (1 cycle latency)
//   access_cnt         saturating count of finished CPU accesses
module dmem_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              hold,
   output logic              hold_ack,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  access_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      CPU_ISSUE,
      CPU_RESP,
      HELD
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state, nstate;

   // op_ld remembers the access type once mem_we has been dropped.
   // rd_iss: a debug read was launched at the last edge.
   // rd_rdy: mem_rdata now holds a debug read result.
   logic op_ld, n_op_ld;
   logic rd_iss, n_rd_iss;
   logic rd_rdy, n_rd_rdy;

   logic              n_mem_en, n_mem_we;
   logic [ADDR_W-1:0] n_mem_addr;
   logic [DATA_W-1:0] n_mem_wdata;
   logic              n_cpu_ack;
   logic [DATA_W-1:0] n_cpu_rdata;
   logic [CNT_W-1:0]  n_access_cnt;
   logic              n_hold_ack;
   logic              n_dbg_valid;
   logic [DATA_W-1:0] n_dbg_rdata;

   assign cpu_stall = (cpu_req & ~cpu_ack) | (state == HELD);

   always_comb begin
      nstate       = state;
      n_op_ld      = op_ld;
      n_rd_iss     = 1'b0;
      n_rd_rdy     = 1'b0;
      n_mem_en     = 1'b0;
      n_mem_we     = 1'b0;
      n_mem_addr   = mem_addr;
      n_mem_wdata  = mem_wdata;
      n_cpu_ack    = 1'b0;
      n_cpu_rdata  = cpu_rdata;
      n_access_cnt = access_cnt;
      n_hold_ack   = 1'b0;
      n_dbg_valid  = 1'b0;
      n_dbg_rdata  = dbg_rdata;
      unique case (state)
         IDLE: begin
            // The debug read stream starts on the entry edge so
            // that data is valid from the 3rd HELD cycle.
            if (hold) begin
               nstate     = HELD;
               n_hold_ack = 1'b1;
               n_mem_en   = 1'b1;
               n_mem_addr = dbg_addr;
               n_rd_iss   = 1'b1;
            // During the ack cycle cpu_req still shows the access
            // just finished; it must not be launched again.
            end else if (cpu_req && !cpu_ack) begin
               nstate      = CPU_ISSUE;
               n_mem_en    = 1'b1;
               n_mem_we    = cpu_we;
               n_mem_addr  = cpu_addr;
               n_mem_wdata = cpu_wdata;
               n_op_ld     = ~cpu_we;
            end
         end
         CPU_ISSUE: begin
            nstate = CPU_RESP;
         end
         CPU_RESP: begin
            nstate    = IDLE;
            n_cpu_ack = 1'b1;
            if (op_ld) begin
               n_cpu_rdata = mem_rdata;
            end
            if (access_cnt != CNT_MAX) begin
               n_access_cnt = access_cnt + CNT_ONE;
            end
         end
         HELD: begin
            if (hold) begin
               n_hold_ack  = 1'b1;
               n_mem_en    = 1'b1;
               n_mem_addr  = dbg_addr;
               n_rd_iss    = 1'b1;
               n_rd_rdy    = rd_iss;
               n_dbg_valid = rd_rdy;
               if (rd_rdy) begin
                  n_dbg_rdata = mem_rdata;
               end
            end else begin
               nstate = IDLE;
            end
         end
         default: begin
            nstate = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         op_ld      <= 1'b0;
         rd_iss     <= 1'b0;
         rd_rdy     <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= '0;
         access_cnt <= '0;
         hold_ack   <= 1'b0;
         dbg_valid  <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         state      <= nstate;
         op_ld      <= n_op_ld;
         rd_iss     <= n_rd_iss;
         rd_rdy     <= n_rd_rdy;
         mem_en     <= n_mem_en;
         mem_we     <= n_mem_we;
         mem_addr   <= n_mem_addr;
         mem_wdata  <= n_mem_wdata;
         cpu_ack    <= n_cpu_ack;
         cpu_rdata  <= n_cpu_rdata;
         access_cnt <= n_access_cnt;
         hold_ack   <= n_hold_ack;
         dbg_valid  <= n_dbg_valid;
         dbg_rdata  <= n_dbg_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for dmem_port_arbiter
// with a behavioural single-port synchronous memory.
module tb_dmem_port_arbiter;

   typedef struct packed {
      logic        ld;
      logic [31:0] rdata;
      logic [3:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [9:0]  cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_stall;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        hold = 1'b0;
   logic        hold_ack;
   logic [9:0]  dbg_addr = '0;
   logic [31:0] dbg_rdata;
   logic        dbg_valid;
   logic        mem_en;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [3:0]  access_cnt;

   logic [31:0] mem [0:1023];
   logic        mem_init = 1'b0;

   int   total = 0;
   int   passed = 0;
   logic [3:0] exp_cnt = '0;
   exp_t cpu_q[$];
   logic [31:0] dbg_q[$];
   exp_t mon_e;
   logic [31:0] mon_d;

   dmem_port_arbiter #(
      .ADDR_W(10),
      .DATA_W(32),
      .CNT_W (4)
   ) dut (
      .clk_in    (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_stall (cpu_stall),
      .cpu_ack   (cpu_ack),
      .cpu_rdata (cpu_rdata),
      .hold      (hold),
      .hold_ack  (hold_ack),
      .dbg_addr  (dbg_addr),
      .dbg_rdata (dbg_rdata),
      .dbg_valid (dbg_valid),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .access_cnt(access_cnt)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) begin
      if (!mem_init) begin
         mem[0]   <= 32'h11;
         mem[1]   <= 32'h22;
         mem[2]   <= 32'h33;
         mem[5]   <= 32'h55;
         mem_init <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst && cpu_ack) begin
         if (cpu_q.size() == 0) begin
            check("ack_expected", 32'(cpu_ack), 32'd0);
         end else begin
            mon_e = cpu_q.pop_front();
            if (mon_e.ld) check("cpu_rdata", cpu_rdata, mon_e.rdata);
            check("access_cnt", 32'(access_cnt), 32'(mon_e.cnt));
         end
      end
      if (rst && dbg_valid) begin
         if (dbg_q.size() == 0) begin
            check("dbg_valid_expected", 32'(dbg_valid), 32'd0);
         end else begin
            mon_d = dbg_q.pop_front();
            check("dbg_rdata", dbg_rdata, mon_d);
         end
      end
      if (rst && hold_ack) check("held_mem_we", 32'(mem_we), 32'd0);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_start(input logic we, input logic [9:0] a,
                            input logic [31:0] wd,
                            input logic [31:0] rd);
      exp_t e;
      exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'h1;
      e.ld    = ~we;
      e.rdata = rd;
      e.cnt   = exp_cnt;
      cpu_q.push_back(e);
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      cpu_req   = 1'b1;
   endtask

   task automatic cpu_wait(input int lat);
      int n;
      bit got;
      n   = 0;
      got = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         tick;
         n = i;
         if (cpu_ack) got = 1;
         else check("stall_wait", 32'(cpu_stall), 32'd1);
      end
      if (!got) begin
         check("ack_timeout", 32'(cpu_ack), 32'd1);
      end else begin
         check("stall_ack", 32'(cpu_stall), 32'd0);
         if (lat > 0) check("ack_latency", 32'(n), 32'(lat));
      end
      tick;
      cpu_req = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
      check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
      check({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
      check({tag, "_hold_ack"}, 32'(hold_ack), 32'd0);
      check({tag, "_dbg_valid"}, 32'(dbg_valid), 32'd0);
      check({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
      check({tag, "_access_cnt"}, 32'(access_cnt), 32'd0);
   endtask

   initial begin
      #1 rst = 1'b0;
      #2 check_zero("por");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      tick;

      // store then load
      cpu_start(1'b1, 10'd3, 32'hDEADBEEF, 32'h0);
      cpu_wait(3);
      cpu_start(1'b0, 10'd3, 32'h0, 32'hDEADBEEF);
      cpu_wait(3);

      // hold rises one cycle after a load is accepted
      dbg_addr = 10'd0;
      cpu_start(1'b0, 10'd0, 32'h0, 32'h11);
      fork
         cpu_wait(3);
         begin
            tick;
            hold = 1'b1;
            tick;
            tick;
            check("hold_ack_in_ack", 32'(hold_ack), 32'd0);
            tick;
            check("hold_ack_after", 32'(hold_ack), 32'd1);
         end
      join

      // debug stream with a store pending behind hold
      dbg_q.push_back(32'h11);
      dbg_q.push_back(32'h22);
      dbg_q.push_back(32'h33);
      dbg_addr = 10'd1;
      cpu_start(1'b1, 10'd7, 32'h77, 32'h0);
      #1 check("held_stall", 32'(cpu_stall), 32'd1);
      tick;
      dbg_addr = 10'd2;
      tick;
      tick;
      tick;
      hold = 1'b0;
      tick;
      check("rel_hold_ack", 32'(hold_ack), 32'd0);
      check("rel_dbg_valid", 32'(dbg_valid), 32'd0);
      check("rel_dbg_rdata", dbg_rdata, 32'h33);
      cpu_wait(3);

      // hold and request in the same idle cycle
      dbg_addr = 10'd2;
      cpu_start(1'b0, 10'd0, 32'h0, 32'h11);
      hold = 1'b1;
      tick;
      check("prio_hold_ack", 32'(hold_ack), 32'd1);
      check("prio_cpu_ack", 32'(cpu_ack), 32'd0);
      check("prio_stall", 32'(cpu_stall), 32'd1);
      dbg_q.push_back(32'h33);
      dbg_q.push_back(32'h33);
      tick;
      tick;
      tick;
      hold = 1'b0;
      tick;
      check("prio_rel_ack", 32'(hold_ack), 32'd0);
      cpu_wait(3);

      // reset in the middle of a store to addr 5
      cpu_start(1'b1, 10'd5, 32'h0BAD0BAD, 32'h0);
      tick;
      #2 rst = 1'b0;
      #1 cpu_req = 1'b0;
      #1 check_zero("mid");
      cpu_q.delete();
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick;
      tick;
      check("mem5_kept", mem[5], 32'h55);
      check("mem7_written", mem[7], 32'h77);

      // saturation of the 4-bit counter
      for (int i = 0; i < 17; i++) begin
         cpu_start(1'b0, 10'(i % 3), 32'h0,
                   32'(17 * (i % 3 + 1)));
         cpu_wait(3);
      end
      check("cnt_saturated", 32'(access_cnt), 32'hF);

      tick;
      tick;
      check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
      check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
